// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-side frame transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HIGH,
        LOW,
        GAP
    } ps2_state_t;

    localparam int   PS2_FRAME_BITS = 11;
    localparam logic PS2_START_BIT  = 1'b0;
    localparam logic PS2_STOP_BIT   = 1'b1;

    // Builds the frame in transmit order, bit 0 first: start, data LSB first, odd parity, stop.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_build_frame(input logic [7:0] data);
        return {PS2_STOP_BIT, ~^data, data, PS2_START_BIT};
    endfunction

endpackage

// File: rtl/ps2_edge_detect.sv
// N-stage synchroniser for an asynchronous level, with a pulse on either edge
// of the synchronised value.
module ps2_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    logic [STAGES-1:0] sync;
    logic              prev;

    // Shift the raw input through the synchroniser and remember the last synchronised value.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= (sync << 1) | STAGES'(raw);
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign pulse = sync[STAGES-1] ^ prev;

endmodule

// File: rtl/ps2_frame_tx.sv
// Device-side PS/2 frame transmitter. Each edge of the divided clock is one
// half-bit phase; accepted bytes go out as 11-bit frames on ps2_clk/ps2_data.
// Optional host inhibit support is enabled with the macro PS2_TX_INHIBIT_EN.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int IDLE_GAP    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       div_clk_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       frame_done
`ifdef PS2_TX_INHIBIT_EN
   ,input  logic       ps2_clk_sense,
    output logic       tx_abort
`endif
);

    localparam int                    GAP_W    = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(IDLE_GAP);
    localparam logic [3:0]            LAST_IDX = 4'(PS2_FRAME_BITS - 1);

    ps2_state_t                state_q, state_d;
    logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]                idx_q, idx_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic                      clk_d, data_d, ready_d, busy_d, done_d;
    logic                      tick;
    logic                      div_level_unused;

    ps2_edge_detect #(.STAGES(SYNC_STAGES)) u_div_edge (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .raw      (div_clk_in),
        .level    (div_level_unused),
        .pulse    (tick)
    );

`ifdef PS2_TX_INHIBIT_EN
    logic sense_level;
    logic sense_pulse_unused;
    logic abort_d;

    ps2_edge_detect #(.STAGES(SYNC_STAGES)) u_sense_sync (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .raw      (ps2_clk_sense),
        .level    (sense_level),
        .pulse    (sense_pulse_unused)
    );
`endif

    // State, frame shifter, counters and all outputs are registered together.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            ps2_clk    <= 1'b1;
            ps2_data   <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef PS2_TX_INHIBIT_EN
            tx_abort   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            ps2_clk    <= clk_d;
            ps2_data   <= data_d;
            tx_ready   <= ready_d;
            busy       <= busy_d;
            frame_done <= done_d;
`ifdef PS2_TX_INHIBIT_EN
            tx_abort   <= abort_d;
`endif
        end
    end

    // Next-state and next-output logic; ticks advance one half-bit phase at a time.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        clk_d   = ps2_clk;
        data_d  = ps2_data;
        done_d  = 1'b0;
`ifdef PS2_TX_INHIBIT_EN
        abort_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (tx_valid && tx_ready) begin
                    shift_d = ps2_build_frame(tx_data);
                    idx_d   = '0;
                    gap_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tick) begin
                    state_d = HIGH;
                    clk_d   = 1'b1;
                    data_d  = shift_q[0];
                end
            end
            HIGH: begin
                if (tick) begin
                    state_d = LOW;
                    clk_d   = 1'b0;
                end
            end
            LOW: begin
                if (tick) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 4'd1;
                        shift_d = {1'b1, shift_q[PS2_FRAME_BITS-1:1]};
                        state_d = HIGH;
                        clk_d   = 1'b1;
                        data_d  = shift_q[1];
                    end else begin
                        done_d  = 1'b1;
                        state_d = GAP;
                        clk_d   = 1'b1;
                        data_d  = 1'b1;
                        gap_d   = '0;
                    end
                end
            end
            GAP: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else if (tick) begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b1;
                data_d  = 1'b1;
            end
        endcase

`ifdef PS2_TX_INHIBIT_EN
        // Host pulling the clock low while we hold it high aborts the frame, up to the parity bit.
        if (!sense_level && ps2_clk && idx_q < LAST_IDX &&
            (state_q == WAIT || state_q == HIGH || state_q == LOW)) begin
            state_d = GAP;
            clk_d   = 1'b1;
            data_d  = 1'b1;
            gap_d   = '0;
            done_d  = 1'b0;
            abort_d = 1'b1;
        end
        ready_d = (state_d == IDLE) && sense_level;
`else
        ready_d = (state_d == IDLE);
`endif
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_ps2_frame_tx.sv
// Directed self-checking bench for ps2_frame_tx. Expected frames are
// hand-computed {stop, parity, data, start} words, bit 0 sent first.
module tb_ps2_frame_tx;

    localparam int HALF = 12;

    logic       clock_in;
    logic       reset_n;
    logic       div_clk_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;
    logic       frame_done;
`ifdef PS2_TX_INHIBIT_EN
    logic       ps2_clk_sense;
    logic       tx_abort;
    int         abort_cnt = 0;
`endif

    int          assert_cnt = 0;
    int          fail_cnt   = 0;
    int          tog_cnt    = 0;
    int          nbits      = 0;
    logic [10:0] cap        = '0;
    logic        clk_prev   = 1'b1;
    logic [10:0] frames[$];
    int          frame_bits[$];
    int          acc_cnt        = 0;
    int          acc_tog_last   = 0;
    int          first_fall_tog = 0;

    ps2_frame_tx #(.IDLE_GAP(4), .SYNC_STAGES(2)) dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .div_clk_in (div_clk_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef PS2_TX_INHIBIT_EN
       ,.ps2_clk_sense (ps2_clk_sense),
        .tx_abort      (tx_abort)
`endif
    );

    // 100 MHz system clock
    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    // Divided square wave, toggled 2 ns after a rising edge every HALF cycles
    initial begin
        div_clk_in = 1'b0;
        forever begin
            repeat (HALF) @(posedge clock_in);
            #2;
            div_clk_in = ~div_clk_in;
            tog_cnt++;
        end
    end

    // Line monitor: samples data on ps2_clk falls, records frames and accepts
    always @(posedge clock_in) begin
        if (clk_prev && !ps2_clk) begin
            if (nbits == 0) first_fall_tog = tog_cnt;
            cap   = {ps2_data, cap[10:1]};
            nbits = nbits + 1;
        end
        clk_prev = ps2_clk;
        if (frame_done) begin
            frames.push_back(cap);
            frame_bits.push_back(nbits);
        end
        if (tx_valid && tx_ready) begin
            acc_cnt      = acc_cnt + 1;
            acc_tog_last = tog_cnt;
            nbits        = 0;
            cap          = '0;
        end
`ifdef PS2_TX_INHIBIT_EN
        if (tx_abort) abort_cnt = abort_cnt + 1;
`endif
    end

    // Watchdog
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clock_in);
            n++;
        end
        checkOutput({tag, "_ready"}, 32'(tx_ready), 32'd1);
    endtask

    task automatic waitFrames(input int count);
        int n = 0;
        while (frames.size() < count && n < 4000) begin
            @(negedge clock_in);
            n++;
        end
    endtask

    // Sends one byte and checks the captured frame, bit count and single frame_done
    task automatic applyStimulus(input logic [7:0] data, input logic [10:0] expected, input string tag);
        int n0;
        waitReady(tag);
        @(negedge clock_in);
        n0       = frames.size();
        tx_data  = data;
        tx_valid = 1'b1;
        @(negedge clock_in);
        tx_valid = 1'b0;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_ready_low"}, 32'(tx_ready), 32'd0);
        waitFrames(n0 + 1);
        checkOutput({tag, "_done"}, frames.size(), n0 + 1);
        if (frames.size() > n0) begin
            checkOutput({tag, "_frame"}, 32'(frames[n0]), 32'(expected));
            checkOutput({tag, "_bits"}, frame_bits[n0], 11);
        end
        repeat (30) @(negedge clock_in);
        checkOutput({tag, "_single_done"}, frames.size(), n0 + 1);
    endtask

    initial begin
        int n, t, t0, base, n0, rh;
        reset_n  = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
`ifdef PS2_TX_INHIBIT_EN
        ps2_clk_sense = 1'b1;
`endif
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_ps2_clk", 32'(ps2_clk), 32'd1);
        checkOutput("rst_ps2_data", 32'(ps2_data), 32'd1);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        repeat (4) @(negedge clock_in);
        reset_n = 1'b1;

        // Basic frame and parity cases
        applyStimulus(8'hA5, 11'h74A, "a5");
        applyStimulus(8'h00, 11'h600, "x00");
        applyStimulus(8'hFF, 11'h7FE, "xff");
        applyStimulus(8'h01, 11'h402, "x01");

        // tx_valid held high: second accept exactly 26 ticks after the first start tick
        waitReady("b2b");
        t = tog_cnt;
        while (tog_cnt == t) @(negedge clock_in);
        repeat (5) @(negedge clock_in);
        base     = acc_cnt;
        n0       = frames.size();
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clock_in);
        checkOutput("b2b_acc1", acc_cnt, base + 1);
        t0      = acc_tog_last;
        tx_data = 8'h34;
        rh = 0;
        n  = 0;
        while (tog_cnt < t0 + 27 && n < 2000) begin
            if (tx_ready) rh++;
            @(negedge clock_in);
            n++;
        end
        checkOutput("b2b_ready_low", rh, 0);
        n = 0;
        while (acc_cnt == base + 1 && n < 200) begin
            @(negedge clock_in);
            n++;
        end
        tx_valid = 1'b0;
        checkOutput("b2b_acc2", acc_cnt, base + 2);
        checkOutput("b2b_gap_ticks", acc_tog_last - (t0 + 1), 26);
        waitFrames(n0 + 2);
        checkOutput("b2b_frames", frames.size(), n0 + 2);
        if (frames.size() >= n0 + 2) begin
            checkOutput("b2b_frame12", 32'(frames[n0]), 32'h624);
            checkOutput("b2b_frame34", 32'(frames[n0 + 1]), 32'h468);
        end

        // Accept coinciding with a tick: start bit waits for the following tick
        waitReady("tickacc");
        repeat (40) @(negedge clock_in);
        t = tog_cnt;
        while (tog_cnt == t) @(negedge clock_in);
        @(negedge clock_in);
        @(negedge clock_in);
        n0       = frames.size();
        base     = acc_cnt;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clock_in);
        tx_valid = 1'b0;
        checkOutput("tickacc_acc", acc_cnt, base + 1);
        waitFrames(n0 + 1);
        checkOutput("tickacc_first_fall", first_fall_tog - acc_tog_last, 2);
        if (frames.size() > n0)
            checkOutput("tickacc_frame", 32'(frames[n0]), 32'h678);

        // Reset during the LOW phase of bit 4
        waitReady("rstmid");
        @(negedge clock_in);
        n0       = frames.size();
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clock_in);
        tx_valid = 1'b0;
        n = 0;
        while (nbits != 5 && n < 2000) begin
            @(negedge clock_in);
            n++;
        end
        checkOutput("rstmid_reach_bit4", nbits, 5);
        @(negedge clock_in);
        checkOutput("rstmid_pre_clk", 32'(ps2_clk), 32'd0);
        checkOutput("rstmid_pre_data", 32'(ps2_data), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstmid_clk", 32'(ps2_clk), 32'd1);
        checkOutput("rstmid_data", 32'(ps2_data), 32'd1);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock_in);
        reset_n = 1'b1;
        repeat (40) @(negedge clock_in);
        checkOutput("rstmid_ready", 32'(tx_ready), 32'd1);
        checkOutput("rstmid_no_done", frames.size(), n0);
        applyStimulus(8'h5A, 11'h6B4, "after_rst");

`ifdef PS2_TX_INHIBIT_EN
        // Host inhibit during bit 3 HIGH
        waitReady("inhibit");
        @(negedge clock_in);
        n0       = frames.size();
        base     = abort_cnt;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clock_in);
        tx_valid = 1'b0;
        n = 0;
        while ((nbits != 3 || !ps2_clk) && n < 2000) begin
            @(negedge clock_in);
            n++;
        end
        checkOutput("inhibit_bit3_high", 32'(ps2_clk), 32'd1);
        ps2_clk_sense = 1'b0;
        repeat (8) @(negedge clock_in);
        checkOutput("inhibit_abort", abort_cnt, base + 1);
        checkOutput("inhibit_clk", 32'(ps2_clk), 32'd1);
        checkOutput("inhibit_data", 32'(ps2_data), 32'd1);
        repeat (HALF * 8) @(negedge clock_in);
        checkOutput("inhibit_ready_held", 32'(tx_ready), 32'd0);
        ps2_clk_sense = 1'b1;
        waitReady("inhibit_release");
        checkOutput("inhibit_single_abort", abort_cnt, base + 1);
        checkOutput("inhibit_no_done", frames.size(), n0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
